// File: rtl/data_cache.sv
// Direct-mapped write-through data cache between MEM stage and data_ram.
// Read hits are combinational; misses and writes run one memory transaction.
module data_cache #(
  parameter int INDEX_WIDTH = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_cs,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_din,
  output logic [31:0] cpu_dout,
  output logic        cpu_stall,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  input  logic        mem_ack
);

  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TW    = 32 - INDEX_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RECOVER
  } state_t;

  state_t state, state_n;

  logic [LINES-1:0] valid;
  logic [TW-1:0]    tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [31:0] rdata;

  logic [INDEX_WIDTH-1:0] idx;
  logic [INDEX_WIDTH-1:0] ridx;
  logic                   hit;
  logic                   req_hit;
  logic                   take;

  assign idx     = cpu_addr[INDEX_WIDTH-1:0];
  assign ridx    = req_addr[INDEX_WIDTH-1:0];
  assign hit     = valid[idx] && (tag_q[idx] == cpu_addr[31:INDEX_WIDTH]);
  assign req_hit = valid[ridx] && (tag_q[ridx] == req_addr[31:INDEX_WIDTH]);
  assign take    = (state == IDLE) && cpu_cs && (cpu_we || !hit);

  // Memory side is decoded only from state and request registers
  assign mem_cs   = (state == READ) || (state == WRITE);
  assign mem_we   = (state == WRITE);
  assign mem_addr = mem_cs ? req_addr : 32'hFFFF_FFFF;
  assign mem_din  = mem_we ? req_data : 32'h0;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state, stall and read data
  always_comb begin
    state_n   = state;
    cpu_stall = 1'b0;
    cpu_dout  = 32'h0;
    unique case (state)
      IDLE: begin
        if (cpu_cs) begin
          if (cpu_we) begin
            cpu_stall = 1'b1;
            state_n   = WRITE;
          end else if (hit) begin
            cpu_dout = data_q[idx];
          end else begin
            cpu_stall = 1'b1;
            state_n   = READ;
          end
        end
      end
      READ: begin
        cpu_stall = 1'b1;
        if (mem_ack) state_n = RECOVER;
      end
      WRITE: begin
        cpu_stall = 1'b1;
        if (mem_ack) state_n = RECOVER;
      end
      RECOVER: begin
        cpu_dout = rdata;
        state_n  = IDLE;
      end
    endcase
  end

  // Request latches, valid bits and returned read data
  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= '0;
      req_addr <= 32'h0;
      req_data <= 32'h0;
      rdata    <= 32'h0;
    end else begin
      if (take) begin
        req_addr <= cpu_addr;
        if (cpu_we) req_data <= cpu_din;
      end
      if (state == READ && mem_ack) begin
        valid[ridx] <= 1'b1;
        rdata       <= mem_dout;
      end
      if (state == WRITE && mem_ack) rdata <= 32'h0;
    end
  end

  // Line tag/data arrays: fill on read ack, update on write hit
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == READ && mem_ack) begin
        tag_q[ridx]  <= req_addr[31:INDEX_WIDTH];
        data_q[ridx] <= mem_dout;
      end else if (state == WRITE && mem_ack && req_hit) begin
        data_q[ridx] <= req_data;
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: 3-cycle-ack memory model and expectation queue.
// Each access pushes its expected result; completion pops and compares.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_cs;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_din;
  logic [31:0] cpu_dout;
  logic        cpu_stall;
  logic        mem_cs;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_ack;

  data_cache #(.INDEX_WIDTH(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_cs    (cpu_cs),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_din   (cpu_din),
    .cpu_dout  (cpu_dout),
    .cpu_stall (cpu_stall),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  int          cnt;
  logic [31:0] prev_addr;

  assign mem_ack  = mem_cs && (cnt == 2) && (mem_addr == prev_addr);
  assign mem_dout = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + i;
      mem[5]    <= 32'h1234_5678;
      cnt       <= 0;
      prev_addr <= 32'hFFFF_FFFF;
    end else begin
      if (mem_cs && mem_addr == prev_addr) cnt <= cnt + 1;
      else if (mem_cs)                     cnt <= 1;
      else                                 cnt <= 0;
      prev_addr <= mem_addr;
      if (mem_cs && mem_we && mem_ack) mem[mem_addr[7:0]] <= mem_din;
    end
  end

  typedef struct {
    logic [31:0] dout;
    int          stalls;
    int          memc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic access(input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] e_dout,
                        input int e_stalls, input int e_memc);
    exp_t        e;
    int          stalls;
    int          memc;
    bit          done;
    bit          unstable;
    logic [31:0] a0;
    logic [31:0] d0;
    logic        w0;
    logic [31:0] dout;
    e.dout   = e_dout;
    e.stalls = e_stalls;
    e.memc   = e_memc;
    exp_q.push_back(e);
    cpu_cs   = 1'b1;
    cpu_we   = we;
    cpu_addr = a;
    cpu_din  = d;
    stalls   = 0;
    memc     = 0;
    done     = 0;
    unstable = 0;
    a0       = 32'h0;
    d0       = 32'h0;
    w0       = 1'b0;
    dout     = 32'h0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (mem_cs) begin
        if (memc == 0) begin
          a0 = mem_addr;
          d0 = mem_din;
          w0 = mem_we;
        end else if (mem_addr !== a0 || mem_din !== d0 || mem_we !== w0) begin
          unstable = 1;
        end
        memc++;
      end
      if (cpu_stall) begin
        stalls++;
      end else begin
        done = 1;
        dout = cpu_dout;
        if (stalls > 0) begin
          check_eq("recover_addr", mem_addr, 32'hFFFF_FFFF);
          check_eq("recover_cs", {31'h0, mem_cs}, 32'h0);
        end
      end
      @(posedge clk);
      #1;
    end
    cpu_cs = 1'b0;
    if (!done) check_eq("timeout", 32'h0, 32'h1);
    e = exp_q.pop_front();
    check_eq("dout", dout, e.dout);
    check_eq("stalls", stalls, e.stalls);
    check_eq("mem_cycles", memc, e.memc);
    if (memc > 0) begin
      check_eq("mem_stable", {31'h0, unstable}, 32'h0);
      check_eq("mem_we", {31'h0, w0}, {31'h0, we});
      check_eq("mem_addr", a0, a);
    end
  endtask

  initial begin
    rst      = 1'b1;
    cpu_cs   = 1'b0;
    cpu_we   = 1'b0;
    cpu_addr = 32'h0;
    cpu_din  = 32'h0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_stall", {31'h0, cpu_stall}, 32'h0);
    check_eq("rst_dout", cpu_dout, 32'h0);
    check_eq("rst_mem_cs", {31'h0, mem_cs}, 32'h0);
    check_eq("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check_eq("rst_mem_addr", mem_addr, 32'hFFFF_FFFF);
    check_eq("rst_mem_din", mem_din, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    access(1'b0, 32'd5, 32'h0, 32'h1234_5678, 4, 3);
    access(1'b0, 32'd5, 32'h0, 32'h1234_5678, 0, 0);

    access(1'b1, 32'd5, 32'hDEAD_BEEF, 32'h0, 4, 3);
    check_eq("mem5", mem[5], 32'hDEAD_BEEF);
    access(1'b0, 32'd5, 32'h0, 32'hDEAD_BEEF, 0, 0);

    access(1'b1, 32'd9, 32'hCAFE_F00D, 32'h0, 4, 3);
    check_eq("mem9", mem[9], 32'hCAFE_F00D);
    access(1'b0, 32'd9, 32'h0, 32'hCAFE_F00D, 4, 3);

    access(1'b0, 32'd2, 32'h0, 32'hA000_0002, 4, 3);
    access(1'b0, 32'd10, 32'h0, 32'hA000_000A, 4, 3);
    access(1'b0, 32'd10, 32'h0, 32'hA000_000A, 0, 0);
    access(1'b0, 32'd2, 32'h0, 32'hA000_0002, 4, 3);

    access(1'b1, 32'd3, 32'h1111_1111, 32'h0, 4, 3);
    access(1'b1, 32'd3, 32'h2222_2222, 32'h0, 4, 3);
    check_eq("mem3", mem[3], 32'h2222_2222);
    access(1'b0, 32'd3, 32'h0, 32'h2222_2222, 4, 3);

    cpu_cs   = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'd6;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("pre_rst_cs", {31'h0, mem_cs}, 32'h1);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    cpu_cs = 1'b0;
    @(negedge clk);
    check_eq("post_rst_cs", {31'h0, mem_cs}, 32'h0);
    check_eq("post_rst_stall", {31'h0, cpu_stall}, 32'h0);
    check_eq("post_rst_addr", mem_addr, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    access(1'b0, 32'd6, 32'h0, 32'hA000_0006, 4, 3);
    access(1'b0, 32'd5, 32'h0, 32'h1234_5678, 4, 3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
